// File: rtl/sram_rr_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared 16x32 SRAM.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface sram_rr_arbiter_if;
    logic        iReqA;
    logic        iLockA;
    logic        iWrnA;
    logic [3:0]  iAddrA;
    logic [31:0] iWrDtA;
    logic        oGntA;
    logic        oRdVldA;
    logic [31:0] oRdDtA;

    logic        iReqB;
    logic        iLockB;
    logic        iWrnB;
    logic [3:0]  iAddrB;
    logic [31:0] iWrDtB;
    logic        oGntB;
    logic        oRdVldB;
    logic [31:0] oRdDtB;

    logic        oCsn;
    logic        oWrn;
    logic [3:0]  oAddr;
    logic [31:0] oWrDt;
    logic [31:0] iRdDt;

    modport slave (
        input  iReqA, iLockA, iWrnA, iAddrA, iWrDtA,
        input  iReqB, iLockB, iWrnB, iAddrB, iWrDtB,
        input  iRdDt,
        output oGntA, oRdVldA, oRdDtA,
        output oGntB, oRdVldB, oRdDtB,
        output oCsn, oWrn, oAddr, oWrDt
    );

    modport master (
        output iReqA, iLockA, iWrnA, iAddrA, iWrDtA,
        output iReqB, iLockB, iWrnB, iAddrB, iWrDtB,
        output iRdDt,
        input  oGntA, oRdVldA, oRdDtA,
        input  oGntB, oRdVldB, oRdDtB,
        input  oCsn, oWrn, oAddr, oWrDt
    );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between ports A and B, with
// capped locked bursts, zero-wait strobes and one-cycle read return.
//
// state | meaning
// IDLE  | no owner; round-robin between requesters using rPrioB
// OWN_A | port A holds a locked burst; B is blocked
// OWN_B | port B holds a locked burst; A is blocked
module sram_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input logic              iClk,
    input logic              iRst,
    sram_rr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_BURST);

    state_t           rState;
    logic             rPrioB;
    logic [CNT_W-1:0] rCnt;
    logic             rVldA;
    logic             rVldB;
    logic [31:0]      rHoldA;
    logic [31:0]      rHoldB;

    logic             gntA;
    logic             gntB;
    logic             arb;
    logic             prioB;
    logic             lockGnt;
    logic [CNT_W:0]   cntInc;
    logic             ownOk;

    assign cntInc = {1'b0, rCnt} + (CNT_W+1)'(1);
    assign ownOk  = ({1'b0, rCnt} < MAX_CNT);

    // An owner that lets go hands arbitration back in the same cycle, with the other port favoured.
    always_comb begin
        gntA  = 1'b0;
        gntB  = 1'b0;
        arb   = 1'b0;
        prioB = rPrioB;
        case (rState)
            OWN_A: begin
                if (bus.iReqA && bus.iLockA && ownOk) begin
                    gntA = 1'b1;
                end else begin
                    arb   = 1'b1;
                    prioB = 1'b1;
                end
            end
            OWN_B: begin
                if (bus.iReqB && bus.iLockB && ownOk) begin
                    gntB = 1'b1;
                end else begin
                    arb   = 1'b1;
                    prioB = 1'b0;
                end
            end
            default: arb = 1'b1;
        endcase
        if (arb) begin
            gntA = bus.iReqA & (~bus.iReqB | ~prioB);
            gntB = bus.iReqB & (~bus.iReqA |  prioB);
        end
        if (iRst) begin
            gntA = 1'b0;
            gntB = 1'b0;
        end
    end

    assign lockGnt = gntA ? bus.iLockA : bus.iLockB;

    always_comb begin
        bus.oCsn  = ~(gntA | gntB);
        bus.oWrn  = 1'b1;
        bus.oAddr = 4'd0;
        bus.oWrDt = 32'd0;
        if (gntA) begin
            bus.oWrn  = bus.iWrnA;
            bus.oAddr = bus.iAddrA;
            bus.oWrDt = bus.iWrDtA;
        end else if (gntB) begin
            bus.oWrn  = bus.iWrnB;
            bus.oAddr = bus.iAddrB;
            bus.oWrDt = bus.iWrDtB;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rState <= IDLE;
            rPrioB <= 1'b0;
            rCnt   <= '0;
            rVldA  <= 1'b0;
            rVldB  <= 1'b0;
            rHoldA <= 32'd0;
            rHoldB <= 32'd0;
        end else begin
            if (!arb) begin
                // Owner beat: release once the cap is reached so the other side gets a turn.
                if (cntInc >= MAX_CNT) begin
                    rState <= IDLE;
                    rCnt   <= '0;
                    rPrioB <= gntA;
                end else begin
                    rCnt <= cntInc[CNT_W-1:0];
                end
            end else if (gntA || gntB) begin
                rPrioB <= gntA;
                if (lockGnt && (MAX_BURST > 1)) begin
                    rState <= gntA ? OWN_A : OWN_B;
                    rCnt   <= CNT_W'(1);
                end else begin
                    rState <= IDLE;
                    rCnt   <= '0;
                end
            end else begin
                rState <= IDLE;
                rCnt   <= '0;
                rPrioB <= prioB;
            end

            rVldA <= gntA & bus.iWrnA;
            rVldB <= gntB & bus.iWrnB;
            if (rVldA) rHoldA <= bus.iRdDt;
            if (rVldB) rHoldB <= bus.iRdDt;
        end
    end

    assign bus.oGntA   = gntA;
    assign bus.oGntB   = gntB;
    assign bus.oRdVldA = rVldA;
    assign bus.oRdVldB = rVldB;
    assign bus.oRdDtA  = rVldA ? bus.iRdDt : rHoldA;
    assign bus.oRdDtB  = rVldB ? bus.iRdDt : rHoldB;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Scoreboard bench for sram_rr_arbiter: directed stimulus pushes expected grants and
// read returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_sram_rr_arbiter;

    typedef struct {
        logic        port;
        logic        wrn;
        logic [3:0]  addr;
        logic [31:0] dt;
    } gnt_t;

    typedef struct {
        logic        port;
        logic [31:0] dt;
    } rd_t;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    gnt_t expG[$];
    rd_t  expR[$];
    gnt_t gE;
    rd_t  rE;

    logic [31:0] mem [16];
    logic [31:0] rdq;

    sram_rr_arbiter_if bus ();

    sram_rr_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus.slave)
    );

    always #5 iClk = ~iClk;

    // Behavioural SRAM: write commits at the strobe edge, read data appears next cycle.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        rdq = 32'd0;
    end
    always @(posedge iClk) begin
        if (!bus.oCsn) begin
            if (!bus.oWrn) mem[bus.oAddr] <= bus.oWrDt;
            else           rdq <= mem[bus.oAddr];
        end
    end
    assign bus.iRdDt = rdq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pushG(input logic p, input logic w, input logic [3:0] a, input logic [31:0] d);
        gnt_t g;
        g.port = p; g.wrn = w; g.addr = a; g.dt = d;
        expG.push_back(g);
    endtask

    task automatic pushR(input logic p, input logic [31:0] d);
        rd_t r;
        r.port = p; r.dt = d;
        expR.push_back(r);
    endtask

    task automatic drv(input logic ra, input logic la, input logic wa, input logic [3:0] aa, input logic [31:0] da,
                       input logic rb, input logic lb, input logic wb, input logic [3:0] ab, input logic [31:0] db);
        bus.iReqA = ra; bus.iLockA = la; bus.iWrnA = wa; bus.iAddrA = aa; bus.iWrDtA = da;
        bus.iReqB = rb; bus.iLockB = lb; bus.iWrnB = wb; bus.iAddrB = ab; bus.iWrDtB = db;
    endtask

    task automatic idle();
        drv(0, 0, 1, 4'd0, 32'd0, 0, 0, 1, 4'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Monitor: grants and SRAM strobes, then read returns.
    always @(negedge iClk) begin
        if (bus.oGntA && bus.oGntB) begin
            checks++; errors++;
            $display("FAIL dual_grant got A=%b B=%b want one", bus.oGntA, bus.oGntB);
        end else if (bus.oGntA || bus.oGntB) begin
            checks++;
            if (expG.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant got port %0d addr %0d want none at %0t", bus.oGntB, bus.oAddr, $time);
            end else begin
                gE = expG.pop_front();
                if (bus.oGntB !== gE.port || bus.oCsn !== 1'b0 || bus.oWrn !== gE.wrn ||
                    bus.oAddr !== gE.addr || (!gE.wrn && bus.oWrDt !== gE.dt)) begin
                    errors++;
                    $display("FAIL grant got port %0d csn %b wrn %b addr %0d dt %h want port %0d csn 0 wrn %b addr %0d dt %h at %0t",
                             bus.oGntB, bus.oCsn, bus.oWrn, bus.oAddr, bus.oWrDt,
                             gE.port, gE.wrn, gE.addr, gE.dt, $time);
                end
            end
        end else begin
            checks++;
            if (bus.oCsn !== 1'b1 || bus.oWrn !== 1'b1 || bus.oAddr !== 4'd0) begin
                errors++;
                $display("FAIL idle_strobe got csn %b wrn %b addr %0d want 1 1 0 at %0t",
                         bus.oCsn, bus.oWrn, bus.oAddr, $time);
            end
        end

        if (bus.oRdVldA && bus.oRdVldB) begin
            checks++; errors++;
            $display("FAIL dual_rdvld got both want one at %0t", $time);
        end else if (bus.oRdVldA || bus.oRdVldB) begin
            checks++;
            if (expR.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rdvld got port %0d want none at %0t", bus.oRdVldB, $time);
            end else begin
                rE = expR.pop_front();
                if (bus.oRdVldB !== rE.port ||
                    (rE.port ? bus.oRdDtB : bus.oRdDtA) !== rE.dt) begin
                    errors++;
                    $display("FAIL rdret got port %0d data %h want port %0d data %h at %0t",
                             bus.oRdVldB, rE.port ? bus.oRdDtB : bus.oRdDtA, rE.port, rE.dt, $time);
                end
            end
        end
    end

    initial begin
        // Reset with both requests raised: grants must stay gated.
        drv(1, 0, 1, 4'd1, 32'd0, 1, 0, 1, 4'd2, 32'd0);
        repeat (3) begin
            @(negedge iClk);
            chk("rst_gntA", {31'd0, bus.oGntA}, 32'd0);
            chk("rst_gntB", {31'd0, bus.oGntB}, 32'd0);
            chk("rst_rdvld", {30'd0, bus.oRdVldA, bus.oRdVldB}, 32'd0);
        end
        @(posedge iClk); #1;
        iRst = 1'b0;
        idle();
        tick();

        // Single write/read on A, then on B.
        drv(1, 0, 0, 4'd3, 32'hDEADBEEF, 0, 0, 1, 4'd0, 32'd0);
        pushG(0, 0, 4'd3, 32'hDEADBEEF);
        tick();
        drv(1, 0, 1, 4'd3, 32'd0, 0, 0, 1, 4'd0, 32'd0);
        pushG(0, 1, 4'd3, 32'd0); pushR(0, 32'hDEADBEEF);
        tick();
        drv(0, 0, 1, 4'd0, 32'd0, 1, 0, 0, 4'd5, 32'h12345678);
        pushG(1, 0, 4'd5, 32'h12345678);
        tick();
        drv(0, 0, 1, 4'd0, 32'd0, 1, 0, 1, 4'd5, 32'd0);
        pushG(1, 1, 4'd5, 32'd0); pushR(1, 32'h12345678);
        tick();
        idle();
        tick();
        @(negedge iClk);
        chk("holdA", bus.oRdDtA, 32'hDEADBEEF);
        chk("holdB", bus.oRdDtB, 32'h12345678);
        tick();

        // Contention from reset: strict alternation starting with A.
        iRst = 1'b1;
        tick(); tick();
        iRst = 1'b0;
        drv(1, 0, 1, 4'd3, 32'd0, 1, 0, 1, 4'd5, 32'd0);
        for (int i = 0; i < 3; i++) begin
            pushG(0, 1, 4'd3, 32'd0); pushR(0, 32'hDEADBEEF);
            pushG(1, 1, 4'd5, 32'd0); pushR(1, 32'h12345678);
        end
        repeat (6) tick();
        idle();
        tick();

        // Locked burst cap: B holds 4 beats, A gets one, B re-locks for 4 more.
        drv(0, 0, 1, 4'd0, 32'd0, 1, 1, 1, 4'd5, 32'd0);
        pushG(1, 1, 4'd5, 32'd0); pushR(1, 32'h12345678);
        tick();
        drv(1, 0, 1, 4'd3, 32'd0, 1, 1, 1, 4'd5, 32'd0);
        for (int i = 0; i < 3; i++) begin
            pushG(1, 1, 4'd5, 32'd0); pushR(1, 32'h12345678);
        end
        pushG(0, 1, 4'd3, 32'd0); pushR(0, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            pushG(1, 1, 4'd5, 32'd0); pushR(1, 32'h12345678);
        end
        pushG(0, 1, 4'd3, 32'd0); pushR(0, 32'hDEADBEEF);
        repeat (9) tick();
        idle();
        tick();

        // Early unlock: A locks two write beats, drops the lock and B wins that cycle.
        iRst = 1'b1;
        tick(); tick();
        iRst = 1'b0;
        drv(1, 1, 0, 4'd9, 32'h11110009, 0, 0, 1, 4'd0, 32'd0);
        pushG(0, 0, 4'd9, 32'h11110009);
        tick();
        drv(1, 1, 0, 4'd10, 32'h2222000A, 1, 0, 0, 4'd11, 32'hBBBB000B);
        pushG(0, 0, 4'd10, 32'h2222000A);
        tick();
        drv(1, 0, 1, 4'd9, 32'd0, 1, 0, 0, 4'd11, 32'hBBBB000B);
        pushG(1, 0, 4'd11, 32'hBBBB000B);
        tick();
        drv(1, 0, 1, 4'd9, 32'd0, 0, 0, 1, 4'd0, 32'd0);
        pushG(0, 1, 4'd9, 32'd0); pushR(0, 32'h11110009);
        tick();
        drv(0, 0, 1, 4'd0, 32'd0, 1, 0, 1, 4'd11, 32'd0);
        pushG(1, 1, 4'd11, 32'd0); pushR(1, 32'hBBBB000B);
        tick();
        drv(1, 0, 1, 4'd10, 32'd0, 0, 0, 1, 4'd0, 32'd0);
        pushG(0, 1, 4'd10, 32'd0); pushR(0, 32'h2222000A);
        tick();
        idle();
        tick();

        // Reset mid-burst with a read in flight: return is dropped, priority back to A.
        iRst = 1'b1;
        tick(); tick();
        iRst = 1'b0;
        drv(1, 1, 1, 4'd3, 32'd0, 1, 0, 1, 4'd5, 32'd0);
        pushG(0, 1, 4'd3, 32'd0); pushR(0, 32'hDEADBEEF);
        tick();
        pushG(0, 1, 4'd3, 32'd0);
        tick();
        iRst = 1'b1;
        @(negedge iClk);
        chk("mid_rst_rdvldA", {31'd0, bus.oRdVldA}, 32'd0);
        chk("mid_rst_csn", {31'd0, bus.oCsn}, 32'd1);
        chk("mid_rst_gntA", {31'd0, bus.oGntA}, 32'd0);
        tick();
        iRst = 1'b0;
        drv(1, 0, 1, 4'd3, 32'd0, 1, 0, 1, 4'd5, 32'd0);
        pushG(0, 1, 4'd3, 32'd0); pushR(0, 32'hDEADBEEF);
        pushG(1, 1, 4'd5, 32'd0); pushR(1, 32'h12345678);
        tick(); tick();
        idle();
        repeat (3) tick();

        chk("gnt_queue_left", expG.size(), 32'd0);
        chk("rd_queue_left", expR.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Two-requester arbiter that shares one 16x32 single-port SRAM between port A (the APB slave interface) and port B (a second bus-side master, e.g. the AHB bridge path).
- Round-robin grant, with optional locked bursts capped at MAX_BURST beats.
- Drives the SRAM strobes (active-low chip select and write enable) and returns read data to the owning requester one cycle later.

Parameters:
- MAX_BURST, 4, max consecutive locked beats one port may hold before forced release (legal 1..16).
- CNT_W, 4, burst counter width (must satisfy 2^CNT_W >= MAX_BURST).

Ports:
- iClk  in  1  rising-edge clock
- iRst  in  1  asynchronous reset, active-high
- iReqA  in  1  port A access request (level; held until granted)
- iLockA  in  1  port A requests burst ownership (sampled with iReqA)
- iWrnA  in  1  port A 0=write, 1=read
- iAddrA  in  4  port A word address
- iWrDtA  in  32  port A write data
- oGntA  out  1  port A granted this cycle (combinational)
- oRdVldA  out  1  port A read data valid (registered)
- oRdDtA  out  32  port A read data
- iReqB, iLockB, iWrnB, iAddrB, iWrDtB, oGntB, oRdVldB, oRdDtB: same as port A, for port B
- oCsn  out  1  SRAM chip select, active-low
- oWrn  out  1  SRAM write enable, active-low
- oAddr  out  4  SRAM word address
- oWrDt  out  32  SRAM write data
- iRdDt  in  32  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Registered state, all cleared asynchronously by iRst:
  - FSM state = IDLE
  - rPrio = A (A wins the next tie)
  - burst counter = 0
  - oRdVldA = oRdVldB = 0
- While iRst is high: oGntA = oGntB = 0, oCsn = 1, oWrn = 1, oAddr = 0.
- The SRAM access issues in the same cycle as the grant (zero-wait).
  - oCsn = ~(oGntA | oGntB).
  - oWrn/oAddr/oWrDt take the granted port's iWrn/iAddr/iWrDt.
  - When idle: oWrn = 1, oAddr = 0; oWrDt is don't-care (drive 0).
- Never both grants in one cycle. A grant is never issued without the matching request.
- FSM states:
  - IDLE
    - Only one port requesting: that port is granted.
    - Both requesting: the rPrio port is granted.
    - After a non-locked grant to X, rPrio flips to the other port.
    - Granted X with iLockX = 1: go to OWN_X, counter = 1.
  - OWN_A / OWN_B
    - Owner X is granted whenever iReqX = 1, iLockX = 1 and counter < MAX_BURST; counter increments per grant. The other port is blocked.
    - Owner drops iReqX or iLockX: return to IDLE this cycle and arbitrate normally with rPrio = other port. The same cycle may grant the other port.
    - Counter reaches MAX_BURST: next cycle forced to IDLE, rPrio = other port, counter = 0. A lock request from the same port is re-arbitrated fairly.
  - MAX_BURST = 1: locking never holds; behaviour degenerates to pure round-robin.
- Read return:
  - A granted read from X sets oRdVldX = 1 the next cycle, with oRdDtX = iRdDt in that cycle.
  - oRdVld is a 1-cycle pulse per read beat. Back-to-back reads give back-to-back pulses.
  - oRdDtX = iRdDt when oRdVldX = 1, else hold the last value.
- A granted write needs no response; data is committed at the grant cycle's clock edge.
- iRst asserted mid-burst or with a read in flight: everything clears immediately, the pending oRdVld is dropped, and no strobe is issued.
- Requests are level-based; a requester deasserting without a grant is legal and leaves no side effect.

Test Plan:
- Reset then idle: iRst = 1 for 3 cycles -> oCsn = 1, oWrn = 1, oGntA = oGntB = 0, oRdVldA/B = 0; after release, still idle with no requests.
- Single write/read on A: write A addr 3 data 0xDEADBEEF (oGntA = 1, oCsn = 0, oWrn = 0, oAddr = 3); read A addr 3 -> oRdVldA pulses the next cycle with oRdDtA = 0xDEADBEEF.
- Contention: A and B both hold non-locked reads for 6 cycles from reset -> grants alternate A, B, A, B, A, B; each oRdVld follows its grant by 1 cycle.
- Locked burst cap (MAX_BURST = 4): B requests with iLockB = 1 continuously and A requests continuously -> B granted 4 consecutive cycles, then A granted, then B re-locks.
- Early unlock: A locks, then drops iLockA after 2 beats while B requests -> B granted in the cycle A unlocks; counter returns to 0.
- Reset mid-burst: assert iRst in the cycle after a granted read within OWN_A -> oRdVldA stays 0, oCsn = 1, state returns to IDLE with rPrio = A.
